// File: rtl/code_loader_pkg.sv
// Shared widths, FSM state encodings and helpers for the byte-stream code loader.
// Build option: define CODE_LOADER_CHECKSUM_EN to require a trailing checksum byte per frame.
package code_loader_pkg;

    localparam int BYTE_W      = 8;
    localparam int CODE_ADDR_W = 8;
    localparam int INSTR_W     = 16;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_COUNT   = 3'd1,
        LD_DATA_HI = 3'd2,
        LD_DATA_LO = 3'd3,
        LD_CHECK   = 3'd4,
        LD_FINISH  = 3'd5,
        LD_FAIL    = 3'd6
    } ld_state_e;

    // The loader takes bytes in every state except the single-cycle end states.
    function automatic logic ld_accepts(input ld_state_e s);
        return !(s == LD_FINISH || s == LD_FAIL);
    endfunction

endpackage

// File: rtl/code_loader_if.sv
// Host byte stream in, code memory write port and status out, as one bundle.
interface code_loader_if;
    import code_loader_pkg::*;

    logic [BYTE_W-1:0]      IN_DATA;
    logic                   IN_VALID;
    logic                   IN_READY;
    logic                   MEM_WE;
    logic [CODE_ADDR_W-1:0] MEM_ADDRESS;
    logic [INSTR_W-1:0]     MEM_DATA;
    logic                   BUSY;
    logic                   DONE;
    logic                   ERROR;

    modport master (
        output IN_DATA, IN_VALID,
        input  IN_READY, MEM_WE, MEM_ADDRESS, MEM_DATA, BUSY, DONE, ERROR
    );

    modport slave (
        input  IN_DATA, IN_VALID,
        output IN_READY, MEM_WE, MEM_ADDRESS, MEM_DATA, BUSY, DONE, ERROR
    );

endinterface

// File: rtl/code_loader_ld_checksum.sv
// 8-bit running-sum accumulator; zero reports whether the sum including this cycle's byte is 0.
module ld_checksum
    import code_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [BYTE_W-1:0] din,
    output logic              zero
);

    logic [BYTE_W-1:0] sum_q, sum_d;

    // Look-ahead flag so the final byte can be judged in the same cycle it arrives.
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = add_en ? din : '0;
        end else if (add_en) begin
            sum_d = sum_q + din;
        end
        zero = (sum_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/code_loader.sv
// Framed byte-stream loader: ADDR, CNT, CNT big-endian words -> code memory writes.
// Build option: CODE_LOADER_CHECKSUM_EN adds a CHK byte and the CHECK/FAIL path.
module code_loader
    import code_loader_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    code_loader_if.slave  ld
);

    ld_state_e              state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   mem_we_q, mem_we_d;
    logic [CODE_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]     mem_data_q, mem_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [CODE_ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0]      cnt_q, cnt_d;
    logic [BYTE_W-1:0]      hi_q, hi_d;
    logic                   accept;

    assign accept = ld.IN_VALID && ready_q;

`ifdef CODE_LOADER_CHECKSUM_EN
    localparam ld_state_e END_ST = LD_CHECK;
    logic sum_clr, sum_add, sum_zero;

    assign sum_clr = accept && (state_q == LD_IDLE);
    assign sum_add = accept;

    ld_checksum u_checksum (
        .clk    (CLK),
        .rst    (RESET),
        .clr    (sum_clr),
        .add_en (sum_add),
        .din    (ld.IN_DATA),
        .zero   (sum_zero)
    );
`else
    localparam ld_state_e END_ST = LD_FINISH;
`endif

    always_comb begin
        state_d    = state_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;

        case (state_q)
            LD_IDLE: if (accept) begin
                addr_d  = ld.IN_DATA;
                busy_d  = 1'b1;
                error_d = 1'b0;
                state_d = LD_COUNT;
            end
            LD_COUNT: if (accept) begin
                cnt_d = ld.IN_DATA;
                if (ld.IN_DATA == '0) begin
                    state_d = END_ST;
                    done_d  = (END_ST == LD_FINISH);
                end else begin
                    state_d = LD_DATA_HI;
                end
            end
            LD_DATA_HI: if (accept) begin
                hi_d    = ld.IN_DATA;
                state_d = LD_DATA_LO;
            end
            LD_DATA_LO: if (accept) begin
                mem_we_d   = 1'b1;
                mem_addr_d = addr_q;
                mem_data_d = {hi_q, ld.IN_DATA};
                addr_d     = addr_q + 8'd1;
                cnt_d      = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = END_ST;
                    done_d  = (END_ST == LD_FINISH);
                end else begin
                    state_d = LD_DATA_HI;
                end
            end
`ifdef CODE_LOADER_CHECKSUM_EN
            LD_CHECK: if (accept) begin
                if (sum_zero) begin
                    state_d = LD_FINISH;
                    done_d  = 1'b1;
                end else begin
                    state_d = LD_FAIL;
                    error_d = 1'b1;
                end
            end
`endif
            LD_FINISH, LD_FAIL: begin
                state_d = LD_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = LD_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Registered ready must already reflect the state being entered.
        ready_d = ld_accepts(state_d);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= LD_IDLE;
            ready_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
        end
    end

    assign ld.IN_READY    = ready_q;
    assign ld.MEM_WE      = mem_we_q;
    assign ld.MEM_ADDRESS = mem_addr_q;
    assign ld.MEM_DATA    = mem_data_q;
    assign ld.BUSY        = busy_q;
    assign ld.DONE        = done_q;
    assign ld.ERROR       = error_q;

endmodule
